// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register downstream of the 16-bit ALU.
// Registers the ALU result, store data, destination and memory/write-back
// enables. Holds the architectural [Z N V] flags, resolves BEZ branches into
// a one-cycle redirect pulse, and runs a squash window that kills the younger
// in-flight instructions. Illegal ALU codes are recorded in a sticky flag.
//
// Ports:
//   CLK, RST                        clock, asynchronous active-low reset
//   Stall                           hold stage (BranchTaken still clears)
//   InValid, CodeULA, Res, FlagReg  EX slot: valid, ALU opcode, result, [Z N V]
//   RegDstIn, RegWrIn, MemRdIn,
//   MemWrIn, StoreDataIn            EX control and store payload
//   ResOut, StoreDataOut, RegDstOut,
//   RegWrOut, MemRdOut, MemWrOut,
//   ValidOut                        registered MEM slot
//   Flags                           architectural status [Z N V]
//   BranchTaken, BranchTarget       redirect pulse and PC
//   Squash                          combinational: squash counter nonzero
//   IllegalOp                       sticky illegal-opcode flag
module ex_mem_stage #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Stall,
    input  logic              InValid,
    input  logic [3:0]        CodeULA,
    input  logic [DATA_W-1:0] Res,
    input  logic [2:0]        FlagReg,
    input  logic [REG_AW-1:0] RegDstIn,
    input  logic              RegWrIn,
    input  logic              MemRdIn,
    input  logic              MemWrIn,
    input  logic [DATA_W-1:0] StoreDataIn,
    output logic [DATA_W-1:0] ResOut,
    output logic [DATA_W-1:0] StoreDataOut,
    output logic [REG_AW-1:0] RegDstOut,
    output logic              RegWrOut,
    output logic              MemRdOut,
    output logic              MemWrOut,
    output logic              ValidOut,
    output logic [2:0]        Flags,
    output logic              BranchTaken,
    output logic [DATA_W-1:0] BranchTarget,
    output logic              Squash,
    output logic              IllegalOp
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);
    localparam logic [3:0] CODE_BEZ = 4'b0110;

    logic [CNT_W-1:0] squashCnt;
    logic squashIdle;
    logic effValid;
    logic isBez;
    logic flagUpd;
    logic takeBranch;
    logic illegalSeen;

    // Slot qualification and branch decode for the instruction now in EX.
    always_comb begin
        squashIdle  = (squashCnt == '0);
        isBez       = (CodeULA == CODE_BEZ);
        effValid    = InValid & squashIdle & ~CodeULA[3];
        flagUpd     = effValid & (CodeULA <= 4'b0101);
        takeBranch  = effValid & isBez & FlagReg[2];
        illegalSeen = InValid & squashIdle & CodeULA[3];
    end

    assign Squash = ~squashIdle;

    // Stage registers; the redirect pulse self-clears even while stalled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ResOut       <= '0;
            StoreDataOut <= '0;
            RegDstOut    <= '0;
            RegWrOut     <= 1'b0;
            MemRdOut     <= 1'b0;
            MemWrOut     <= 1'b0;
            ValidOut     <= 1'b0;
            Flags        <= 3'b000;
            BranchTaken  <= 1'b0;
            BranchTarget <= '0;
            squashCnt    <= '0;
            IllegalOp    <= 1'b0;
        end else begin
            BranchTaken <= 1'b0;
            if (!Stall) begin
                ResOut       <= Res;
                StoreDataOut <= StoreDataIn;
                RegDstOut    <= RegDstIn;
                ValidOut     <= effValid;
                // BEZ never writes registers or memory.
                RegWrOut     <= RegWrIn & effValid & ~isBez;
                MemRdOut     <= MemRdIn & effValid & ~isBez;
                MemWrOut     <= MemWrIn & effValid & ~isBez;
                if (flagUpd) begin
                    Flags <= FlagReg;
                end
                if (takeBranch) begin
                    BranchTaken  <= 1'b1;
                    BranchTarget <= Res;
                    squashCnt    <= FLUSH_INIT;
                end else if (!squashIdle) begin
                    squashCnt <= squashCnt - CNT_W'(1);
                end
                if (illegalSeen) begin
                    IllegalOp <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: a driver applies stimulus on the falling
// edge and pushes the predicted post-edge outputs; a monitor pops and compares
// just after each rising edge.
module tb_ex_mem_stage;

    localparam int FLUSH = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Stall = 1'b0;
    logic        InValid = 1'b0;
    logic [3:0]  CodeULA = '0;
    logic [15:0] Res = '0;
    logic [2:0]  FlagReg = '0;
    logic [2:0]  RegDstIn = '0;
    logic        RegWrIn = 1'b0;
    logic        MemRdIn = 1'b0;
    logic        MemWrIn = 1'b0;
    logic [15:0] StoreDataIn = '0;
    logic [15:0] ResOut, StoreDataOut, BranchTarget;
    logic [2:0]  RegDstOut, Flags;
    logic        RegWrOut, MemRdOut, MemWrOut, ValidOut;
    logic        BranchTaken, Squash, IllegalOp;

    ex_mem_stage #(.DATA_W(16), .REG_AW(3), .FLUSH_CYCLES(FLUSH)) dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .InValid(InValid),
        .CodeULA(CodeULA), .Res(Res), .FlagReg(FlagReg), .RegDstIn(RegDstIn),
        .RegWrIn(RegWrIn), .MemRdIn(MemRdIn), .MemWrIn(MemWrIn),
        .StoreDataIn(StoreDataIn), .ResOut(ResOut), .StoreDataOut(StoreDataOut),
        .RegDstOut(RegDstOut), .RegWrOut(RegWrOut), .MemRdOut(MemRdOut),
        .MemWrOut(MemWrOut), .ValidOut(ValidOut), .Flags(Flags),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Squash(Squash), .IllegalOp(IllegalOp)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] sd;
        logic [2:0]  dst;
        logic        rw, mr, mw, v;
        logic [2:0]  flags;
        logic        bt;
        logic [15:0] tgt;
        logic        sq;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t mOut;
    exp_t monExp;
    int   mSquashLeft = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic checkAll(input exp_t e);
        chk("ResOut", 32'(ResOut), 32'(e.res));
        chk("StoreDataOut", 32'(StoreDataOut), 32'(e.sd));
        chk("RegDstOut", 32'(RegDstOut), 32'(e.dst));
        chk("RegWrOut", 32'(RegWrOut), 32'(e.rw));
        chk("MemRdOut", 32'(MemRdOut), 32'(e.mr));
        chk("MemWrOut", 32'(MemWrOut), 32'(e.mw));
        chk("ValidOut", 32'(ValidOut), 32'(e.v));
        chk("Flags", 32'(Flags), 32'(e.flags));
        chk("BranchTaken", 32'(BranchTaken), 32'(e.bt));
        chk("BranchTarget", 32'(BranchTarget), 32'(e.tgt));
        chk("Squash", 32'(Squash), 32'(e.sq));
        chk("IllegalOp", 32'(IllegalOp), 32'(e.ill));
    endtask

    // Apply one slot's inputs and predict the outputs after the next rising edge.
    task automatic apply(input logic st, input logic v, input logic [3:0] c,
                         input logic [15:0] r, input logic [2:0] f, input logic [2:0] d,
                         input logic rw, input logic mr, input logic mw,
                         input logic [15:0] s);
        exp_t e;
        bit   live, accepted, bez;
        Stall = st; InValid = v; CodeULA = c; Res = r; FlagReg = f;
        RegDstIn = d; RegWrIn = rw; MemRdIn = mr; MemWrIn = mw; StoreDataIn = s;
        e = mOut;
        e.bt = 1'b0;
        if (!st) begin
            live     = v && (mSquashLeft == 0);
            accepted = live && (c < 4'd8);
            bez      = (c == 4'd6);
            e.res = r; e.sd = s; e.dst = d; e.v = accepted;
            e.rw = accepted && !bez && rw;
            e.mr = accepted && !bez && mr;
            e.mw = accepted && !bez && mw;
            if (accepted && c <= 4'd5) e.flags = f;
            if (live && c >= 4'd8) e.ill = 1'b1;
            if (accepted && bez && f[2]) begin
                e.bt = 1'b1;
                e.tgt = r;
                mSquashLeft = FLUSH;
            end else if (mSquashLeft > 0) begin
                mSquashLeft--;
            end
        end
        e.sq = (mSquashLeft > 0);
        mOut = e;
        q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic v, input logic [3:0] c,
                         input logic [15:0] r, input logic [2:0] f, input logic [2:0] d,
                         input logic rw, input logic mr, input logic mw,
                         input logic [15:0] s);
        @(negedge CLK);
        apply(st, v, c, r, f, d, rw, mr, mw, s);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd7, 16'h0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Async reset mid-cycle: outputs must clear without waiting for a clock edge.
    task automatic resetPulse();
        @(negedge CLK);
        #2;
        RST = 1'b0;
        mOut = '0;
        mSquashLeft = 0;
        #1;
        checkAll('0);
        @(negedge CLK);
        RST = 1'b1;
        apply(1'b0, 1'b0, 4'd7, 16'h0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                monExp = q.pop_front();
                checkAll(monExp);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : driver
        logic [3:0] c;
        mOut = '0;
        resetPulse();

        // ADD with N,V set
        drive(0, 1, 4'd0, 16'h8000, 3'b011, 3'd5, 1, 0, 0, 16'h1234);
        // Taken BEZ, two squashed ADDs, then an accepted ADD
        drive(0, 1, 4'd6, 16'h0040, 3'b100, 3'd1, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd0, 16'h1111, 3'b100, 3'd2, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd0, 16'h2222, 3'b110, 3'd3, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd0, 16'h3333, 3'b001, 3'd4, 1, 0, 0, 16'h0);
        // Not-taken BEZ
        drive(0, 1, 4'd6, 16'h0080, 3'b000, 3'd1, 1, 1, 1, 16'h0);
        idle();
        // Stall during squash
        drive(0, 1, 4'd6, 16'h0100, 3'b111, 3'd1, 0, 0, 0, 16'h0);
        repeat (3) drive(1, 1, 4'd0, 16'hdead, 3'b010, 3'd6, 1, 1, 1, 16'hbeef);
        drive(0, 1, 4'd0, 16'h4444, 3'b010, 3'd6, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd6, 16'h5555, 3'b100, 3'd6, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd2, 16'h6666, 3'b101, 3'd7, 1, 0, 0, 16'h0);
        // Illegal code with store
        drive(0, 1, 4'd10, 16'h7777, 3'b111, 3'd2, 0, 0, 1, 16'habcd);
        drive(0, 1, 4'd1, 16'h0001, 3'b000, 3'd2, 1, 0, 0, 16'h0);
        drive(0, 1, 4'd4, 16'h0002, 3'b010, 3'd3, 0, 1, 0, 16'h0);
        // Reset while the squash window and redirect pulse are both active
        drive(0, 1, 4'd6, 16'h0200, 3'b100, 3'd0, 0, 0, 0, 16'h0);
        resetPulse();
        idle();

        // Random traffic with BEZ bias, stalls and occasional illegal codes
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 4'd6 : 4'($urandom_range(0, 15));
            if (c >= 4'd8 && $urandom_range(0, 3) != 0) c = c - 4'd8;
            drive(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) != 0), c,
                  16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom));
        end

        idle();
        @(negedge CLK);
        @(negedge CLK);
        chk("queueDrain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
